conv1_spike_sequencer: RTL

CONV1_SPIKE_SEQUENCER -- requirements
Module: conv1_spike_sequencer

---
 rtl/conv1_spike_sequencer_pkg.sv | 16 +
 rtl/conv1_spike_sequencer_skid.sv | 58 +++++
 rtl/conv1_spike_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/conv1_spike_sequencer_pkg.sv
// Shared widths and FSM encoding for the conv1 spike sequencer and its skid FIFO.
package conv1_spike_sequencer_pkg;

  localparam int CONV1_ADDR_DEF    = 9;
  localparam int SYNAPSE_INDEX_DEF = 16;
  localparam int RD_LAT_DEF        = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DRAIN   = 3'd2,
    RELEASE = 3'd3,
    HOLD    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/conv1_spike_sequencer_skid.sv
// spike_skid_fifo: small fall-through FIFO that absorbs RAM words returning while
// the conv1 array is stalled.
module spike_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/conv1_spike_sequencer.sv
// Reads one frame of spike indices out of the ping-pong spike RAM and streams them to conv1.
// Optional feature: define CONV1_SPIKE_STAT_EN to report the accepted spike count per frame.
module conv1_spike_sequencer
  import conv1_spike_sequencer_pkg::*;
#(
  parameter int CONV1_ADDR    = CONV1_ADDR_DEF,
  parameter int SYNAPSE_INDEX = SYNAPSE_INDEX_DEF,
  parameter int RD_LAT        = RD_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     addr_valid,
  input  logic [CONV1_ADDR-1:0]    addr_most,
  input  logic [SYNAPSE_INDEX-1:0] s_index_ram,
  output logic [CONV1_ADDR-1:0]    addr_r_spike,
  output logic                     ram_release,
  output logic                     spike_valid,
  output logic [SYNAPSE_INDEX-1:0] spike_index,
  input  logic                     spike_ready,
  output logic                     frame_done,
  output logic [CONV1_ADDR-1:0]    frame_spike_cnt
);

  localparam int                FIFO_DEPTH = RD_LAT + 1;
  localparam int                CRED_W     = $clog2(RD_LAT + 2);
  localparam logic [CRED_W-1:0] CRED_INIT  = CRED_W'(RD_LAT + 1);

  seq_state_t               state;
  logic [CONV1_ADDR-1:0]    last_addr;
  logic [CONV1_ADDR-1:0]    next_addr;
  logic [CRED_W-1:0]        credits;
  logic                     rd_issue;
  logic [RD_LAT-1:0]        vld_sr;
  logic                     hold_cnt;
  logic                     issue;
  logic                     accept;
  logic                     load_out;
  logic                     drained;
  logic                     fifo_push;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [SYNAPSE_INDEX-1:0] fifo_rdata;

  assign next_addr = addr_r_spike + CONV1_ADDR'(1);
  assign issue     = (state == ISSUE) && (credits != '0);
  assign accept    = spike_valid && spike_ready;
  assign fifo_push = vld_sr[RD_LAT-1] && !fifo_full;
  assign load_out  = !fifo_empty && (!spike_valid || spike_ready);
  // Frame is finished once nothing is in flight and the last held spike is leaving.
  assign drained   = !rd_issue && (vld_sr == '0) && fifo_empty && (!spike_valid || spike_ready);

  spike_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYNAPSE_INDEX)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (s_index_ram),
    .pop   (load_out),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_addr    <= '0;
      addr_r_spike <= '0;
      rd_issue     <= 1'b0;
      ram_release  <= 1'b0;
      frame_done   <= 1'b0;
      hold_cnt     <= 1'b0;
    end else begin
      rd_issue    <= issue;
      ram_release <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_valid) begin
            last_addr <= addr_most;
            if (addr_most == '0) begin
              state       <= RELEASE;
              ram_release <= 1'b1;
              frame_done  <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_r_spike <= next_addr;
            if (next_addr == last_addr) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state        <= RELEASE;
            ram_release  <= 1'b1;
            frame_done   <= 1'b1;
            addr_r_spike <= '0;
          end
        end
        RELEASE: begin
          state    <= HOLD;
          hold_cnt <= 1'b0;
        end
        HOLD: begin
          // Two idle cycles let the RAM controller swap banks before addr_valid is resampled.
          if (hold_cnt) state <= IDLE;
          else          hold_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits     <= CRED_INIT;
      vld_sr      <= '0;
      spike_valid <= 1'b0;
      spike_index <= '0;
    end else begin
      vld_sr[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      case ({issue, accept})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: credits <= credits;
      endcase
      if (load_out) begin
        spike_valid <= 1'b1;
        spike_index <= fifo_rdata;
      end else if (accept) begin
        spike_valid <= 1'b0;
      end
    end
  end

`ifdef CONV1_SPIKE_STAT_EN
  logic [CONV1_ADDR-1:0] spike_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_cnt       <= '0;
      frame_spike_cnt <= '0;
    end else begin
      if (state == IDLE && addr_valid) spike_cnt <= '0;
      else if (accept)                 spike_cnt <= spike_cnt + CONV1_ADDR'(1);
      if (state == RELEASE) frame_spike_cnt <= spike_cnt;
    end
  end
`else
  assign frame_spike_cnt = '0;
`endif

endmodule
